// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and defaults for the fetch/decode path
package cpu_pkg;

   localparam int DATA_W            = 32;
   localparam int FDQ_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [DATA_W-1:0] pc_plus_1;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fdq_storage.sv
// rtl/fdq_storage.sv - entry register array, one synchronous write port, one asynchronous read port
module fdq_storage
   import cpu_pkg::*;
#(
   parameter int  DEPTH   = FDQ_DEPTH_DEFAULT,
   parameter type entry_t = fetch_entry_t,
   localparam int AW      = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  entry_t        wr_data,
   input  logic [AW-1:0] rd_addr,
   output entry_t        rd_data
);

   // No reset: stale contents are never visible because the top gates the output.
   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction queue with flush on redirect
// Optional zero-latency bypass when empty: define FDQ_BYPASS_EN.
module fetch_decode_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH  = FDQ_DEPTH_DEFAULT,
   parameter int DATA_W = cpu_pkg::DATA_W
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_pc_plus_1,
   input  logic [DATA_W-1:0]          in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_pc_plus_1,
   output logic [DATA_W-1:0]          out_instr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [DATA_W-1:0] pc_plus_1;
      logic [DATA_W-1:0] instr;
   } entry_t;

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] occ;
   logic          push;
   logic          pop;
   logic          bypass;
   entry_t        wr_entry;
   entry_t        head;

   assign full     = (occ == CW'(DEPTH));
   assign empty    = (occ == '0);
   assign count    = occ;
   assign in_ready = ~full;

`ifdef FDQ_BYPASS_EN
   assign bypass = empty & in_valid & ~flush;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = ~empty | bypass;
   assign pop       = ~empty & out_ready & ~flush;
   // A bypassed entry taken by decode this cycle never enters storage.
   assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);

   assign wr_entry.pc_plus_1 = in_pc_plus_1;
   assign wr_entry.instr     = in_instr;

   fdq_storage #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_storage (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   always_comb begin
      out_pc_plus_1 = '0;
      out_instr     = '0;
      if (bypass) begin
         out_pc_plus_1 = in_pc_plus_1;
         out_instr     = in_instr;
      end else if (!empty) begin
         out_pc_plus_1 = head.pc_plus_1;
         out_instr     = head.instr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule
